scaler_linear_h: RTL and testbench
==================================

SCALER_LINEAR_H -- requirements
Module: scaler_h

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 PIXEL_WIDTH, 12, pixel bit width
 COE_WIDTH, 10, coefficient width; unity weight = 2^(COE_WIDTH-1); requires COE_WIDTH-1 <= log2(STEP)
 STEP, 4096, fixed-point 1.000 horizontal pixel pitch (power of 2)
REQ-002 Ports (name  direction  width  meaning):
 clk  in  1  single clock
 rst  in  1  reset, synchronous, active-high
 scale_step  in  16  input-pitch advance per output pixel (STEP units); sampled on de_i&hs_i
 line_in_size  in  16  input pixels per line; sampled on de_i&hs_i
 line_out_size  in  16  output pixels per line; sampled on de_i&hs_i
 di_i  in  PIXEL_WIDTH  input pixel (vertical-scaler output stream)
 de_i / hs_i / vs_i  in  1 each  pixel valid / first pixel of line / first pixel of frame (hs_i, vs_i qualified by de_i)
 do_o  out  PIXEL_WIDTH  scaled pixel
 de_o / hs_o / vs_o  out  1 each  same semantics as inputs, for output stream
 ovf_o  out  1  sticky overrun flag

Function
REQ-003 Input pixel k sits at position k*STEP; output pixel j at j*scale_step; cnt_i = position of newest pixel p1, p0 = previous pixel.
REQ-004 FSM states IDLE, ACTIVE, FLUSH; de_i&hs_i in any state -> ACTIVE, cnt_i=0, cnt_o=0, out_cnt=0, in_cnt=1, p0=p1=di_i, frame flag=vs_i.
REQ-005 In ACTIVE, each de_i without hs_i: p0<=p1, p1<=di_i, cnt_i+=STEP, in_cnt+=1; de_i in IDLE without hs_i ignored.
REQ-006 Generation: one output per clock while cnt_o < cnt_i and out_cnt < line_out_size; each output: cnt_o+=scale_step, out_cnt+=1.
REQ-007 Generation for a new pixel starts the cycle after de_i is sampled.
REQ-008 When in_cnt == line_in_size and cnt_o >= cnt_i: go to FLUSH, inject one replica pixel (p0<=p1, cnt_i+=STEP) next cycle, right-edge replication.
REQ-009 When out_cnt reaches line_out_size: go to IDLE; further de_i without hs_i ignored.
REQ-010 dx = cnt_o - (cnt_i - STEP), log2(STEP) bits; coe1 = dx >> (log2(STEP)-COE_WIDTH+1); coe0 = 2^(COE_WIDTH-1) - coe1.
REQ-011 sum = coe0*p0 + coe1*p1 + 2^(COE_WIDTH-2); do_o = sum[COE_WIDTH-1 +: PIXEL_WIDTH]; if sum >= 2^(PIXEL_WIDTH+COE_WIDTH-1), do_o = 2^PIXEL_WIDTH-1.
REQ-012 Pipeline: generation (t), coefficient/operand register (t+1), multiply (t+2), sum (t+3), clamp to do_o (t+4); de_o/hs_o/vs_o aligned to do_o.
REQ-013 hs_o asserted with de_o on out_cnt==0 output; vs_o additionally requires frame flag; do_o holds last value when de_o=0.
REQ-014 Overrun: de_i arriving while cnt_o < cnt_i and out_cnt < line_out_size -> pending outputs of old interval dropped, cnt_o<=old cnt_i, ovf_o<=1.
REQ-015 de_i&hs_i while line incomplete (ACTIVE/FLUSH, out_cnt < line_out_size) -> remaining outputs dropped, ovf_o<=1, new line starts.
REQ-016 ovf_o cleared on de_i&vs_i (that same pixel's overrun, if any, sets it again) or rst.
REQ-017 Required rate: STEP/scale_step <= (empty cycles between input pixels)+1.

Reset
REQ-018 rst: state IDLE, all counters 0, pipeline valids 0, do_o=0, de_o=hs_o=vs_o=0, ovf_o=0 from the cycle after rst is sampled.
REQ-019 rst mid-line: in-flight pixels discarded; no de_o until outputs of the next de_i&hs_i line.

Structure
REQ-020 Shared package holds STEP default, unity/round constants and FSM state encoding, shared with scaler_v.
REQ-021 No sub-module; coefficients computed inline (no table), multipliers inferred.

Verification
REQ-022 scale_step=4096, in=out=8, ramp 0..700 step 100, one empty cycle/pixel -> do_o identical ramp, 8 de_o, hs_o on first, 5-cycle latency from pixel 1 de_i.
REQ-023 scale_step=2048, in=4 {0,400,800,1200}, out=8, one empty cycle -> 0,200,400,600,800,1000,1200,1200.
REQ-024 scale_step=8192, in=8 ramp 0..700, out=4 -> 0,200,400,600; trailing input ignored.
REQ-025 scale_step=1024, no empty cycles -> ovf_o=1 after second pixel, held until next de_i&vs_i.
REQ-026 all inputs 4095, any scale_step -> do_o=4095, no wrap.
REQ-027 rst one cycle at 3rd output -> all outputs 0 next cycle, no de_o until next line's first output.

Source files
------------

// File: rtl/scaler_linear_h_pkg.sv
// rtl/scaler_linear_h_pkg.sv - constants and FSM encoding shared by the horizontal and vertical scalers
package scaler_linear_h_pkg;

    localparam int STEP_DEFAULT = 4096;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    function automatic int coe_unity(input int coe_width);
        return 1 << (coe_width - 1);
    endfunction

    function automatic int coe_round(input int coe_width);
        return 1 << (coe_width - 2);
    endfunction

endpackage

// File: rtl/scaler_linear_h.sv
// rtl/scaler_linear_h.sv - horizontal linear-interpolation scaler with 5-stage output pipeline
module scaler_linear_h
    import scaler_linear_h_pkg::*;
#(
    parameter int PIXEL_WIDTH = 12,
    parameter int COE_WIDTH   = 10,
    parameter int STEP        = STEP_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            scale_step,
    input  logic [15:0]            line_in_size,
    input  logic [15:0]            line_out_size,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   ovf_o
);

    localparam int LOG2_STEP = $clog2(STEP);
    localparam int SHIFT     = LOG2_STEP - COE_WIDTH + 1;
    localparam int SUM_W     = PIXEL_WIDTH + COE_WIDTH + 1;
    localparam int CNT_W     = 32;
    localparam logic [CNT_W-1:0]     STEP_C  = CNT_W'(STEP);
    localparam logic [COE_WIDTH-1:0] UNITY_C = COE_WIDTH'(coe_unity(COE_WIDTH));
    localparam logic [SUM_W-1:0]     ROUND_C = SUM_W'(coe_round(COE_WIDTH));
    localparam logic [SUM_W-1:0]     SAT_C   = SUM_W'(1) << (PIXEL_WIDTH + COE_WIDTH - 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt_i, cnt_o, cnt_o_nxt, step_ext;
    logic [15:0]            in_cnt, out_cnt, out_cnt_nxt, step_r, in_size_r, out_size_r;
    logic [PIXEL_WIDTH-1:0] p0, p1;
    logic                   frame, replica_done;
    logic                   start, line_open, gen, take_px, overrun;
    logic [LOG2_STEP-1:0]   dx;

    logic                   g_vld, g_hs, g_vs, c_vld, c_hs, c_vs;
    logic                   m_vld, m_hs, m_vs, s_vld, s_hs, s_vs;
    logic [LOG2_STEP-1:0]   g_dx;
    logic [PIXEL_WIDTH-1:0] g_p0, g_p1, c_p0, c_p1;
    logic [COE_WIDTH-1:0]   coe1, c_coe0, c_coe1;
    logic [SUM_W-1:0]       m_prod0, m_prod1, s_sum;

    assign step_ext    = {16'd0, step_r};
    assign cnt_o_nxt   = cnt_o + step_ext;
    assign out_cnt_nxt = out_cnt + 16'd1;
    assign start       = de_i && hs_i;
    assign line_open   = (state != ST_IDLE) && (out_cnt < out_size_r);
    assign gen         = line_open && (cnt_o < cnt_i) && !start;
    assign take_px     = de_i && !hs_i && (state == ST_ACTIVE) && line_open && (in_cnt < in_size_r);
    // Overrun only when outputs would still be pending after this cycle's generation.
    assign overrun     = take_px && gen && (cnt_o_nxt < cnt_i) && (out_cnt_nxt < out_size_r);
    // cnt_i is always a multiple of STEP, so the low bits of (cnt_i - STEP) equal those of cnt_i.
    assign dx          = cnt_o[LOG2_STEP-1:0] - cnt_i[LOG2_STEP-1:0];
    assign coe1        = COE_WIDTH'(g_dx >> SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt_i        <= '0;
            cnt_o        <= '0;
            in_cnt       <= '0;
            out_cnt      <= '0;
            step_r       <= '0;
            in_size_r    <= '0;
            out_size_r   <= '0;
            p0           <= '0;
            p1           <= '0;
            frame        <= 1'b0;
            replica_done <= 1'b0;
            ovf_o        <= 1'b0;
        end else begin
            if (de_i && vs_i)
                ovf_o <= 1'b0;
            if (overrun || (start && line_open))
                ovf_o <= 1'b1;

            if (start) begin
                state        <= ST_ACTIVE;
                cnt_i        <= '0;
                cnt_o        <= '0;
                out_cnt      <= '0;
                in_cnt       <= 16'd1;
                p0           <= di_i;
                p1           <= di_i;
                frame        <= vs_i;
                step_r       <= scale_step;
                in_size_r    <= line_in_size;
                out_size_r   <= line_out_size;
                replica_done <= 1'b0;
            end else if (state != ST_IDLE) begin
                if (!line_open) begin
                    state <= ST_IDLE;
                end else begin
                    if (gen) begin
                        cnt_o   <= cnt_o_nxt;
                        out_cnt <= out_cnt_nxt;
                    end
                    if (take_px) begin
                        p0     <= p1;
                        p1     <= di_i;
                        cnt_i  <= cnt_i + STEP_C;
                        in_cnt <= in_cnt + 16'd1;
                        if (overrun)
                            cnt_o <= cnt_i;
                    end else if (state == ST_ACTIVE && in_cnt >= in_size_r && !gen) begin
                        state <= ST_FLUSH;
                    end else if (state == ST_FLUSH && !replica_done) begin
                        // Right-edge replication: the last pixel becomes its own neighbour.
                        p0           <= p1;
                        cnt_i        <= cnt_i + STEP_C;
                        replica_done <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_vld <= 1'b0;
            c_vld <= 1'b0;
            m_vld <= 1'b0;
            s_vld <= 1'b0;
            do_o  <= '0;
            de_o  <= 1'b0;
            hs_o  <= 1'b0;
            vs_o  <= 1'b0;
        end else begin
            g_vld <= gen;
            g_hs  <= gen && (out_cnt == 16'd0);
            g_vs  <= gen && (out_cnt == 16'd0) && frame;
            g_dx  <= dx;
            g_p0  <= p0;
            g_p1  <= p1;

            c_vld  <= g_vld;
            c_hs   <= g_hs;
            c_vs   <= g_vs;
            c_coe1 <= coe1;
            c_coe0 <= UNITY_C - coe1;
            c_p0   <= g_p0;
            c_p1   <= g_p1;

            m_vld   <= c_vld;
            m_hs    <= c_hs;
            m_vs    <= c_vs;
            m_prod0 <= SUM_W'(c_coe0) * SUM_W'(c_p0);
            m_prod1 <= SUM_W'(c_coe1) * SUM_W'(c_p1);

            s_vld <= m_vld;
            s_hs  <= m_hs;
            s_vs  <= m_vs;
            s_sum <= m_prod0 + m_prod1 + ROUND_C;

            de_o <= s_vld;
            hs_o <= s_vld && s_hs;
            vs_o <= s_vld && s_vs;
            if (s_vld)
                do_o <= (s_sum >= SAT_C) ? '1 : s_sum[COE_WIDTH-1 +: PIXEL_WIDTH];
        end
    end

endmodule

// File: tb/tb_scaler_linear_h.sv
// tb/tb_scaler_linear_h.sv - directed self-checking bench for scaler_linear_h
module tb_scaler_linear_h;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] scale_step, line_in_size, line_out_size;
    logic [11:0] di_i;
    logic        de_i, hs_i, vs_i;
    logic [11:0] do_o;
    logic        de_o, hs_o, vs_o, ovf_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int px1_cyc = 0;
    bit rst_armed = 1'b0;
    int pix [0:15];
    int exp_d [0:15];
    int out_d [$];
    int out_h [$];
    int out_v [$];
    int out_c [$];

    scaler_linear_h dut (
        .clk(clk), .rst(rst),
        .scale_step(scale_step), .line_in_size(line_in_size), .line_out_size(line_out_size),
        .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (de_o) begin
            out_d.push_back(int'(do_o));
            out_h.push_back(int'(hs_o));
            out_v.push_back(int'(vs_o));
            out_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst && rst_armed) begin
            rst = 1'b0;
            rst_armed = 1'b0;
            chk("rst_do", int'(do_o), 0);
            chk("rst_de", int'(de_o), 0);
            chk("rst_hs", int'(hs_o), 0);
            chk("rst_vs", int'(vs_o), 0);
            chk("rst_ovf", int'(ovf_o), 0);
        end else if (rst_armed && de_o && out_d.size() == 2) begin
            rst = 1'b1;
        end
    endtask

    task automatic clr();
        out_d.delete();
        out_h.delete();
        out_v.delete();
        out_c.delete();
    endtask

    task automatic drive_line(input int n, input int gap, input logic vs, input int step,
                              input int isz, input int osz);
        for (int k = 0; k < n; k++) begin
            de_i = 1'b1;
            hs_i = (k == 0);
            vs_i = (k == 0) && vs;
            di_i = 12'(pix[k]);
            scale_step = 16'(step);
            line_in_size = 16'(isz);
            line_out_size = 16'(osz);
            tick();
            if (k == 1) px1_cyc = cyc;
            de_i = 1'b0;
            hs_i = 1'b0;
            vs_i = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic wait_out(input int n, input int budget);
        int b = 0;
        while (out_d.size() < n && b < budget) begin
            tick();
            b++;
        end
        repeat (8) tick();
    endtask

    task automatic check_vals(input string tag, input int n);
        chk({tag, "_count"}, out_d.size(), n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_d%0d", tag, i), (i < out_d.size()) ? out_d[i] : -1, exp_d[i]);
        chk({tag, "_hs0"}, (out_h.size() > 0) ? out_h[0] : -1, 1);
    endtask

    initial begin
        rst = 1'b1;
        de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; di_i = '0;
        scale_step = '0; line_in_size = '0; line_out_size = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_do", int'(do_o), 0);
        chk("reset_de", int'(de_o), 0);
        chk("reset_hs", int'(hs_o), 0);
        chk("reset_vs", int'(vs_o), 0);
        chk("reset_ovf", int'(ovf_o), 0);
        rst = 1'b0;
        tick();

        // unity scale, identical ramp, 5-cycle latency
        clr();
        for (int i = 0; i < 8; i++) begin pix[i] = i * 100; exp_d[i] = i * 100; end
        drive_line(8, 1, 1'b1, 4096, 8, 8);
        wait_out(8, 40);
        check_vals("unity", 8);
        chk("unity_hs_total", out_h.sum(), 1);
        chk("unity_vs0", (out_v.size() > 0) ? out_v[0] : -1, 1);
        chk("unity_latency", (out_c.size() > 0) ? out_c[0] - px1_cyc : -1, 5);
        chk("unity_ovf", int'(ovf_o), 0);
        chk("hold_do", int'(do_o), 700);
        chk("hold_de", int'(de_o), 0);

        // 2x upscale with right-edge replication
        clr();
        pix[0] = 0; pix[1] = 400; pix[2] = 800; pix[3] = 1200;
        exp_d[0] = 0;   exp_d[1] = 200;  exp_d[2] = 400;  exp_d[3] = 600;
        exp_d[4] = 800; exp_d[5] = 1000; exp_d[6] = 1200; exp_d[7] = 1200;
        drive_line(4, 1, 1'b0, 2048, 4, 8);
        wait_out(8, 40);
        check_vals("up2", 8);
        chk("up2_vs_total", out_v.sum(), 0);
        chk("up2_ovf", int'(ovf_o), 0);

        // 2x downscale, trailing input ignored
        clr();
        for (int i = 0; i < 9; i++) pix[i] = i * 100;
        exp_d[0] = 0; exp_d[1] = 200; exp_d[2] = 400; exp_d[3] = 600;
        drive_line(9, 1, 1'b0, 8192, 8, 4);
        wait_out(4, 40);
        check_vals("down2", 4);
        chk("down2_ovf", int'(ovf_o), 0);

        // full-scale input must not wrap
        clr();
        for (int i = 0; i < 4; i++) pix[i] = 4095;
        for (int i = 0; i < 6; i++) exp_d[i] = 4095;
        drive_line(4, 1, 1'b0, 3072, 4, 6);
        wait_out(6, 40);
        check_vals("sat", 6);

        // overrun: 4x upscale with back-to-back pixels
        clr();
        for (int i = 0; i < 8; i++) pix[i] = i * 100;
        scale_step = 16'd1024; line_in_size = 16'd8; line_out_size = 16'd12;
        de_i = 1'b1; hs_i = 1'b1; vs_i = 1'b1; di_i = 12'(pix[0]);
        tick();
        hs_i = 1'b0; vs_i = 1'b0; di_i = 12'(pix[1]);
        tick();
        chk("ovf_before", int'(ovf_o), 0);
        di_i = 12'(pix[2]);
        tick();
        chk("ovf_set", int'(ovf_o), 1);
        for (int i = 3; i < 8; i++) begin
            di_i = 12'(pix[i]);
            tick();
        end
        de_i = 1'b0;
        wait_out(12, 60);
        chk("ovf_hold", int'(ovf_o), 1);

        clr();
        pix[0] = 10; pix[1] = 20; exp_d[0] = 10; exp_d[1] = 20;
        drive_line(2, 1, 1'b0, 4096, 2, 2);
        wait_out(2, 30);
        check_vals("novs", 2);
        chk("ovf_hold_novs", int'(ovf_o), 1);

        clr();
        drive_line(2, 1, 1'b1, 4096, 2, 2);
        wait_out(2, 30);
        check_vals("vsclr", 2);
        chk("vsclr_vs0", (out_v.size() > 0) ? out_v[0] : -1, 1);
        chk("ovf_cleared", int'(ovf_o), 0);

        // new line before the previous one completes
        clr();
        for (int i = 0; i < 4; i++) pix[i] = i * 100;
        drive_line(4, 1, 1'b0, 4096, 8, 8);
        pix[0] = 10; pix[1] = 20;
        drive_line(2, 1, 1'b0, 4096, 2, 2);
        wait_out(5, 40);
        chk("abort_ovf", int'(ovf_o), 1);
        chk("abort_count", out_d.size(), 5);
        chk("abort_d2", (out_d.size() > 2) ? out_d[2] : -1, 200);
        chk("abort_d3", (out_d.size() > 3) ? out_d[3] : -1, 10);
        chk("abort_d4", (out_d.size() > 4) ? out_d[4] : -1, 20);
        chk("abort_hs3", (out_h.size() > 3) ? out_h[3] : -1, 1);

        // reset pulse on the third output of a line
        clr();
        for (int i = 0; i < 8; i++) pix[i] = i * 100;
        rst_armed = 1'b1;
        drive_line(8, 1, 1'b1, 4096, 8, 8);
        repeat (12) tick();
        chk("midrst_count", out_d.size(), 3);
        chk("midrst_d2", (out_d.size() > 2) ? out_d[2] : -1, 200);
        chk("midrst_armed", int'(rst_armed), 0);

        clr();
        pix[0] = 10; pix[1] = 20; exp_d[0] = 10; exp_d[1] = 20;
        drive_line(2, 1, 1'b1, 4096, 2, 2);
        wait_out(2, 30);
        check_vals("postrst", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
